fifo_mq_rd_sched: RTL
=====================

// Module: fifo_mq_rd_sched
// PURPOSE
//  Read-side scheduler for the multi-queue async FIFO. Runs in the FIFO read clock domain.
//  Watches the per-queue empty flags and picks one non-empty, enabled queue per cycle
//  (round-robin). Drives the one-hot read strobe and captures the shared data word one cycle later.
//  Presents each word with its queue id on a valid/ready stream for the egress logic.
// PARAMETERS
//  nr_of_queues  16  number of queues; width of fifo_empty, read and queue_en
//  data_width    36  width of q and dout
//  qid_width     4   width of dout_qid; must satisfy 2**qid_width >= nr_of_queues
// PORTS
//  clk         in   1                    read-domain clock; all logic on rising edge
//  rst         in   1                    synchronous reset, active high
//  fifo_empty  in   [0:nr_of_queues-1]   per-queue empty flags from the FIFO
//  queue_en    in   [0:nr_of_queues-1]   per-queue read enable; 0 = queue never scheduled
//  read        out  [0:nr_of_queues-1]   one-hot (or zero) read strobe to the FIFO
//  q           in   data_width           FIFO read data; valid the cycle after read[i]
//  dout        out  data_width           output data word
//  dout_qid    out  qid_width            queue index the word came from
//  dout_valid  out  1                    dout/dout_qid valid
//  dout_ready  in   1                    consumer accepts the word when valid & ready
// BEHAVIOUR
//  - Reset: read=0, dout_valid=0, dout=0, dout_qid=0.
//    Round-robin pointer=0, lock mask=0, inflight=0, buffer count=0.
//  - Eligibility: elig[i] = ~fifo_empty[i] & queue_en[i] & ~lock[i].
//  - lock[i] is set for exactly the one cycle after read[i]. This covers the empty-flag update
//    lag, so a single-entry queue is never over-read.
//    As a result, one queue is read at most every other cycle.
//  - Grant: the first eligible index at or after ptr, wrapping nr_of_queues-1 -> 0.
//    On grant ptr <= grant+1 (mod nr_of_queues). With no grant, ptr holds.
//  - Credit: the output buffer holds 2 entries.
//    Issue allowed iff count + inflight - (dout_valid & dout_ready) < 2.
//    read is combinational from registered state, fifo_empty, queue_en and dout_ready.
//    read has no other combinational inputs.
//  - Issue: read[grant]=1 for one cycle; inflight <= 1 and inflight_qid <= grant.
//    With no grant or no credit, read=0 and inflight <= 0.
//  - Capture: when inflight=1, q is written into the buffer at the end of that cycle with
//    inflight_qid. Latency from read[i] to dout_valid is 2 cycles when the buffer is empty.
//  - Output: a 2-entry FIFO, head drives dout/dout_qid.
//    dout_valid = (count != 0). While valid & ~ready, dout and dout_qid stay stable.
//    A push and a pop in the same cycle leave count unchanged. Words leave in grant order.
//    No word is dropped or duplicated.
//  - Throughput: 1 word/cycle when at least 2 queues are eligible and dout_ready=1.
//    1 word per 2 cycles when only one queue is eligible.
//  - dout_ready=0: at most 2 words are pending (buffer plus inflight). After that read stays 0.
//  - queue_en deassert: takes effect next grant decision. An inflight word from that queue
//    is still delivered.
//  - rst mid-operation: all state is cleared the next cycle and any inflight word is discarded.
//    The FIFO read pointer has already advanced, so the FIFO read side must be reset together
//    with this block.
//  - Assertions: read is one-hot or zero. read & fifo_empty == 0. count <= 2.
// TESTING
//  1. rst, all fifo_empty=1 for 20 cycles -> read=0, dout_valid=0 throughout.
//  2. Only queue 3 non-empty, q=36'h0_0000_0AB3, ready=1 -> read[3] every 2nd cycle.
//     Each word appears 2 cycles later with dout_qid=3 and dout=36'h0_0000_0AB3.
//  3. Queues 0, 5, 15 always non-empty, ready=1 -> reads every cycle in order 0,5,15,0,5,...
//     dout_qid follows the same sequence, delayed by 2 cycles.
//  4. All queues non-empty, dout_ready=0 -> exactly 2 reads, then read=0 and dout held stable.
//     Then ready=1 -> 2 buffered words, then streaming resumes, with no loss or duplicate.
//  5. queue_en[5]=0, queues 4, 5, 6 non-empty -> read[5] never asserted; 4 and 6 alternate.
//  6. rst pulsed in the cycle read[2]=1 -> next cycle dout_valid=0, read=0, ptr=0.
//     No stale word is ever output.

Source files
------------

// File: rtl/fifo_mq_rd_sched_if.sv
// Read-side bundle between the multi-queue FIFO, its read scheduler and the egress consumer.
// master is the scheduler's view; slave is the FIFO/egress side.
interface fifo_mq_rd_sched_if #(
  parameter int unsigned NR_OF_QUEUES = 16,
  parameter int unsigned DATA_WIDTH   = 36,
  parameter int unsigned QID_WIDTH    = 4
);
  logic [0:NR_OF_QUEUES-1] fifo_empty;
  logic [0:NR_OF_QUEUES-1] queue_en;
  logic [0:NR_OF_QUEUES-1] read;
  logic [DATA_WIDTH-1:0]   q;
  logic [DATA_WIDTH-1:0]   dout;
  logic [QID_WIDTH-1:0]    dout_qid;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    input  fifo_empty, queue_en, q, dout_ready,
    output read, dout, dout_qid, dout_valid
  );

  modport slave (
    output fifo_empty, queue_en, q, dout_ready,
    input  read, dout, dout_qid, dout_valid
  );
endinterface

// File: rtl/fifo_mq_rd_sched.sv
// Round-robin read scheduler for the multi-queue FIFO: issues one-hot read strobes under
// a 2-entry credit and streams captured words with their queue id on valid/ready.
module fifo_mq_rd_sched #(
  parameter int unsigned NR_OF_QUEUES = 16,
  parameter int unsigned DATA_WIDTH   = 36,
  parameter int unsigned QID_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_mq_rd_sched_if.master      bus
);
  localparam int unsigned NQ    = NR_OF_QUEUES;
  localparam int unsigned PTR_W = (NQ > 1) ? $clog2(NQ) : 1;

  typedef struct packed {
    logic [QID_WIDTH-1:0]  qid;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [0:NQ-1]        lock_q, lock_d;
  logic                 inflight_q, inflight_d;
  logic [QID_WIDTH-1:0] inflight_qid_q, inflight_qid_d;
  entry_t               buf_q [2];
  entry_t               buf_d [2];
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [1:0]           cnt_q, cnt_d;

  logic [0:NQ-1]        elig_c;
  logic [0:NQ-1]        read_c;
  logic                 pop_c;
  logic [2:0]           pend_c;
  logic                 found_c;
  logic                 issue_c;
  logic [PTR_W-1:0]     grant_c;
  int unsigned          idx_c;

  // Grant search, credit check and next-state for pointer, lock, inflight and output buffer
  always_comb begin
    ptr_d          = ptr_q;
    lock_d         = '0;
    inflight_d     = 1'b0;
    inflight_qid_d = inflight_qid_q;
    buf_d          = buf_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    read_c         = '0;
    found_c        = 1'b0;
    grant_c        = '0;
    idx_c          = 0;

    elig_c = ~bus.fifo_empty & bus.queue_en & ~lock_q;
    pop_c  = (cnt_q != 2'd0) && bus.dout_ready;
    pend_c = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_c);

    // Scan from the far end so the nearest eligible index at/after ptr wins last
    for (int k = int'(NQ) - 1; k >= 0; k--) begin
      idx_c = int'(ptr_q) + k;
      if (idx_c >= NQ) idx_c = idx_c - NQ;
      if (elig_c[idx_c]) begin
        found_c = 1'b1;
        grant_c = PTR_W'(idx_c);
      end
    end

    issue_c = found_c && (pend_c < 3'd2);
    if (issue_c) begin
      read_c[grant_c] = 1'b1;
      ptr_d           = (grant_c == PTR_W'(NQ - 1)) ? '0 : grant_c + PTR_W'(1);
      inflight_d      = 1'b1;
      inflight_qid_d  = QID_WIDTH'(grant_c);
    end
    lock_d = read_c;

    if (inflight_q) begin
      buf_d[wr_q] = '{qid: inflight_qid_q, data: bus.q};
      wr_d        = ~wr_q;
    end
    if (pop_c) rd_d = ~rd_q;
    cnt_d = cnt_q + 2'(inflight_q) - 2'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      lock_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_qid_q <= '0;
      buf_q[0]       <= '0;
      buf_q[1]       <= '0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      cnt_q          <= 2'd0;
    end else begin
      ptr_q          <= ptr_d;
      lock_q         <= lock_d;
      inflight_q     <= inflight_d;
      inflight_qid_q <= inflight_qid_d;
      buf_q[0]       <= buf_d[0];
      buf_q[1]       <= buf_d[1];
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.read       = read_c;
  assign bus.dout       = buf_q[rd_q].data;
  assign bus.dout_qid   = buf_q[rd_q].qid;
  assign bus.dout_valid = (cnt_q != 2'd0);

  a_read_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.read));
  a_read_nonempty: assert property (@(posedge clk) disable iff (rst)
    (bus.read & bus.fifo_empty) == '0);
  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= 2'd2);
endmodule
